// File: rtl/letter_pool.sv
// Pool of falling letters: captures spawned letters into free slots, advances them on each
// frame tick, and retires them on a matching key (hit) or when they reach the floor (miss).
module letter_pool #(
   parameter  int NSLOT   = 8,
   parameter  int X_FLOOR = 470,
   parameter  int CW      = 16,
   localparam int IW      = $clog2(NSLOT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spawn,
   input  logic [7:0]    gen_ch,
   input  logic [2:0]    gen_speed,
   input  logic [8:0]    gen_x,
   input  logic [9:0]    gen_y,
   input  logic          frame_tick,
   input  logic          key_valid,
   input  logic [7:0]    key_ascii,
   input  logic [IW-1:0] rd_idx,
   output logic          rd_active,
   output logic [7:0]    rd_ch,
   output logic [8:0]    rd_x,
   output logic [9:0]    rd_y,
   output logic          hit,
   output logic          miss,
   output logic          overflow,
   output logic [CW-1:0] hit_count,
   output logic [CW-1:0] miss_count,
   output logic [IW:0]   n_active
);

   logic          act_q [NSLOT];
   logic [7:0]    ch_q  [NSLOT];
   logic [2:0]    spd_q [NSLOT];
   logic [8:0]    x_q   [NSLOT];
   logic [9:0]    y_q   [NSLOT];
   logic          act_d [NSLOT];
   logic [7:0]    ch_d  [NSLOT];
   logic [2:0]    spd_d [NSLOT];
   logic [8:0]    x_d   [NSLOT];
   logic [9:0]    y_d   [NSLOT];

   logic          hit_q, miss_q, ovf_q;
   logic          hit_d, miss_d, ovf_d;
   logic [CW-1:0] hcnt_q, mcnt_q, hcnt_d, mcnt_d;
   logic [IW:0]   nact_q, nact_d;

   logic          tgt_vld, free_vld;
   logic [IW-1:0] tgt_idx, free_idx;
   logic [8:0]    tgt_x;
   logic [9:0]    nx;
   logic [IW:0]   miss_n;

   function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [IW:0] b);
      logic [CW+IW+1:0] s;
      s = {{(IW+2){1'b0}}, a} + {{(CW+1){1'b0}}, b};
      if (s > {{(IW+2){1'b0}}, {CW{1'b1}}})
         return '1;
      return s[CW-1:0];
   endfunction

   // Key target: deepest matching letter, lowest index on a tie (strict > keeps the first).
   always_comb begin
      tgt_vld = 1'b0;
      tgt_idx = '0;
      tgt_x   = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (key_valid && act_q[i] && (ch_q[i] == key_ascii) && (!tgt_vld || (x_q[i] > tgt_x))) begin
            tgt_vld = 1'b1;
            tgt_idx = IW'(i);
            tgt_x   = x_q[i];
         end
      end
   end

   always_comb begin
      free_vld = 1'b0;
      free_idx = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (!act_q[i] && !free_vld) begin
            free_vld = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   // Spawn only targets a slot that was free before this edge, so it never collides with a
   // slot retired in the same edge and is never advanced on its own spawn edge.
   always_comb begin
      nx     = '0;
      miss_n = '0;
      nact_d = '0;
      for (int i = 0; i < NSLOT; i++) begin
         act_d[i] = act_q[i];
         ch_d[i]  = ch_q[i];
         spd_d[i] = spd_q[i];
         x_d[i]   = x_q[i];
         y_d[i]   = y_q[i];
         nx       = {1'b0, x_q[i]} + {7'b0, spd_q[i]};
         if (tgt_vld && (tgt_idx == IW'(i))) begin
            act_d[i] = 1'b0;
            ch_d[i]  = '0;
            spd_d[i] = '0;
            x_d[i]   = '0;
            y_d[i]   = '0;
         end else if (frame_tick && act_q[i]) begin
            if (nx >= 10'(X_FLOOR)) begin
               act_d[i] = 1'b0;
               ch_d[i]  = '0;
               spd_d[i] = '0;
               x_d[i]   = '0;
               y_d[i]   = '0;
               miss_n   = miss_n + (IW+1)'(1);
            end else begin
               x_d[i] = nx[8:0];
            end
         end
         if (spawn && free_vld && (free_idx == IW'(i))) begin
            act_d[i] = 1'b1;
            ch_d[i]  = gen_ch;
            spd_d[i] = gen_speed;
            x_d[i]   = gen_x;
            y_d[i]   = gen_y;
         end
         if (act_d[i])
            nact_d = nact_d + (IW+1)'(1);
      end
   end

   always_comb begin
      hit_d  = tgt_vld;
      miss_d = (miss_n != '0);
      ovf_d  = spawn && !free_vld;
      hcnt_d = tgt_vld ? sat_add(hcnt_q, (IW+1)'(1)) : hcnt_q;
      mcnt_d = sat_add(mcnt_q, miss_n);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSLOT; i++) begin
            act_q[i] <= 1'b0;
            ch_q[i]  <= '0;
            spd_q[i] <= '0;
            x_q[i]   <= '0;
            y_q[i]   <= '0;
         end
         hit_q  <= 1'b0;
         miss_q <= 1'b0;
         ovf_q  <= 1'b0;
         hcnt_q <= '0;
         mcnt_q <= '0;
         nact_q <= '0;
      end else begin
         for (int i = 0; i < NSLOT; i++) begin
            act_q[i] <= act_d[i];
            ch_q[i]  <= ch_d[i];
            spd_q[i] <= spd_d[i];
            x_q[i]   <= x_d[i];
            y_q[i]   <= y_d[i];
         end
         hit_q  <= hit_d;
         miss_q <= miss_d;
         ovf_q  <= ovf_d;
         hcnt_q <= hcnt_d;
         mcnt_q <= mcnt_d;
         nact_q <= nact_d;
      end
   end

   // Indices beyond NSLOT match no slot and read back as zero.
   always_comb begin
      rd_active = 1'b0;
      rd_ch     = '0;
      rd_x      = '0;
      rd_y      = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if ((rd_idx == IW'(i)) && act_q[i]) begin
            rd_active = 1'b1;
            rd_ch     = ch_q[i];
            rd_x      = x_q[i];
            rd_y      = y_q[i];
         end
      end
   end

   assign hit        = hit_q;
   assign miss       = miss_q;
   assign overflow   = ovf_q;
   assign hit_count  = hcnt_q;
   assign miss_count = mcnt_q;
   assign n_active   = nact_q;

endmodule

// File: tb/tb_letter_pool.sv
// Bench for letter_pool: directed scenarios then random traffic, all checked against a
// slot-list reference model; counters built 4 bits wide so saturation is reachable.
module tb_letter_pool;
   localparam int NSLOT = 8;
   localparam int XF    = 470;
   localparam int CW    = 4;
   localparam int MAXC  = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b0, spawn = 1'b0, frame_tick = 1'b0, key_valid = 1'b0;
   logic [7:0]  gen_ch = '0, key_ascii = '0;
   logic [2:0]  gen_speed = '0;
   logic [8:0]  gen_x = '0;
   logic [9:0]  gen_y = '0;
   logic [2:0]  rd_idx = '0;
   logic        rd_active, hit, miss, overflow;
   logic [7:0]  rd_ch;
   logic [8:0]  rd_x;
   logic [9:0]  rd_y;
   logic [CW-1:0] hit_count, miss_count;
   logic [3:0]  n_active;

   always #10 clk = ~clk;

   letter_pool #(.NSLOT(NSLOT), .X_FLOOR(XF), .CW(CW)) dut (
      .clk(clk), .rst(rst), .spawn(spawn), .gen_ch(gen_ch), .gen_speed(gen_speed),
      .gen_x(gen_x), .gen_y(gen_y), .frame_tick(frame_tick), .key_valid(key_valid),
      .key_ascii(key_ascii), .rd_idx(rd_idx), .rd_active(rd_active), .rd_ch(rd_ch),
      .rd_x(rd_x), .rd_y(rd_y), .hit(hit), .miss(miss), .overflow(overflow),
      .hit_count(hit_count), .miss_count(miss_count), .n_active(n_active)
   );

   // Reference model: a plain list of letters with their positions.
   bit m_act [NSLOT];
   int m_ch [NSLOT], m_spd [NSLOT], m_x [NSLOT], m_y [NSLOT];
   int e_hit = 0, e_miss = 0, e_ovf = 0, e_hcnt = 0, e_mcnt = 0;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int r, sp, ch, spd, x, y, ft, kv, ka);
      int tgt, fr, nmiss;
      e_hit = 0; e_miss = 0; e_ovf = 0;
      if (r != 0) begin
         for (int i = 0; i < NSLOT; i++) m_act[i] = 0;
         e_hcnt = 0;
         e_mcnt = 0;
      end else begin
         tgt = -1; fr = -1; nmiss = 0;
         for (int i = 0; i < NSLOT; i++)
            if (kv != 0 && m_act[i] && m_ch[i] == ka && (tgt < 0 || m_x[i] > m_x[tgt])) tgt = i;
         for (int i = 0; i < NSLOT; i++)
            if (!m_act[i] && fr < 0) fr = i;
         if (tgt >= 0) begin
            m_act[tgt] = 0;
            e_hit = 1;
            e_hcnt = (e_hcnt + 1 > MAXC) ? MAXC : e_hcnt + 1;
         end
         if (ft != 0)
            for (int i = 0; i < NSLOT; i++)
               if (m_act[i]) begin
                  if (m_x[i] + m_spd[i] >= XF) begin
                     m_act[i] = 0;
                     nmiss++;
                  end else begin
                     m_x[i] = m_x[i] + m_spd[i];
                  end
               end
         e_miss = (nmiss > 0) ? 1 : 0;
         e_mcnt = (e_mcnt + nmiss > MAXC) ? MAXC : e_mcnt + nmiss;
         if (sp != 0) begin
            if (fr >= 0) begin
               m_act[fr] = 1; m_ch[fr] = ch & 255; m_spd[fr] = spd & 7;
               m_x[fr] = x & 511; m_y[fr] = y & 1023;
            end else begin
               e_ovf = 1;
            end
         end
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < NSLOT; i++) if (m_act[i]) n++;
      return n;
   endfunction

   task automatic cyc(input int r, sp, ch, spd, x, y, ft, kv, ka);
      logic [31:0] exp_slot;
      rst = (r != 0); spawn = (sp != 0); gen_ch = 8'(ch); gen_speed = 3'(spd);
      gen_x = 9'(x); gen_y = 10'(y); frame_tick = (ft != 0); key_valid = (kv != 0);
      key_ascii = 8'(ka);
      @(posedge clk);
      model(r, sp, ch, spd, x, y, ft, kv, ka);
      #1;
      rst = 1'b0; spawn = 1'b0; frame_tick = 1'b0; key_valid = 1'b0;
      check("hit", 32'(hit), 32'(e_hit));
      check("miss", 32'(miss), 32'(e_miss));
      check("overflow", 32'(overflow), 32'(e_ovf));
      check("hit_count", 32'(hit_count), 32'(e_hcnt));
      check("miss_count", 32'(miss_count), 32'(e_mcnt));
      check("n_active", 32'(n_active), 32'(model_count()));
      for (int i = 0; i < NSLOT; i++) begin
         rd_idx = 3'(i);
         #1;
         exp_slot = m_act[i] ? {4'b0, 1'b1, 8'(m_ch[i]), 9'(m_x[i]), 10'(m_y[i])} : 32'h0;
         check($sformatf("slot%0d", i), {4'b0, rd_active, rd_ch, rd_x, rd_y}, exp_slot);
      end
   endtask

   task automatic peek(input int idx, input string tag, input int a, ch, x, y);
      rd_idx = 3'(idx);
      #1;
      check(tag, {4'b0, rd_active, rd_ch, rd_x, rd_y},
            (a != 0) ? {4'b0, 1'b1, 8'(ch), 9'(x), 10'(y)} : 32'h0);
   endtask

   initial begin
      int r, sp, ch, spd, x, y, ft, kv, ka;
      // Test 1: reset and a single spawn
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_nact", 32'(n_active), 32'd0);
      check("rst_hcnt", 32'(hit_count), 32'd0);
      cyc(0, 1, 'h41, 2, 0, 90, 0, 0, 0);
      peek(0, "t1_slot0", 1, 'h41, 0, 90);
      check("t1_nact", 32'(n_active), 32'd1);

      // Test 2: falling and floor crossing
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 'h42, 3, 0, 7, 0, 0, 0);
      repeat (5) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      peek(0, "t2_x15", 1, 'h42, 15, 7);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 'h42, 3, 468, 7, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("t2_miss", 32'(miss), 32'd1);
      check("t2_mcnt", 32'(miss_count), 32'd1);
      peek(0, "t2_gone", 0, 0, 0, 0);

      // Test 3: key picks the deepest match
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 'h41, 1, 20, 1, 0, 0, 0);
      cyc(0, 1, 'h43, 1, 50, 2, 0, 0, 0);
      cyc(0, 1, 'h41, 1, 100, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 'h41);
      check("t3_hit", 32'(hit), 32'd1);
      peek(2, "t3_slot2", 0, 0, 0, 0);
      peek(0, "t3_slot0", 1, 'h41, 20, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 'h5A);
      check("t3_nohit", 32'(hit), 32'd0);
      check("t3_nact", 32'(n_active), 32'd2);

      // Test 4: full pool drops spawns, even when a key frees a slot that edge
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NSLOT; i++) cyc(0, 1, 'h41 + i, 1, i * 10, i, 0, 0, 0);
      cyc(0, 1, 'h50, 1, 0, 0, 0, 0, 0);
      check("t4_ovf", 32'(overflow), 32'd1);
      check("t4_nact", 32'(n_active), 32'd8);
      cyc(0, 1, 'h50, 1, 0, 0, 0, 1, 'h41);
      check("t4_ovf2", 32'(overflow), 32'd1);
      check("t4_hit2", 32'(hit), 32'd1);
      check("t4_nact2", 32'(n_active), 32'd7);

      // Test 5: key, frame and spawn on one edge
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 'h41, 1, 10, 0, 0, 0, 0);
      cyc(0, 1, 'h42, 2, 10, 1, 0, 0, 0);
      cyc(0, 1, 'h43, 3, 10, 2, 0, 0, 0);
      cyc(0, 1, 'h44, 4, 10, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 'h44);
      cyc(0, 1, 'h45, 5, 5, 9, 1, 1, 'h42);
      peek(1, "t5_slot1", 0, 0, 0, 0);
      peek(0, "t5_slot0", 1, 'h41, 11, 0);
      peek(2, "t5_slot2", 1, 'h43, 13, 2);
      peek(3, "t5_slot3", 1, 'h45, 5, 9);

      // Test 6: hit counter saturation, then reset mid-fall
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (17) begin
         cyc(0, 1, 'h41, 0, 0, 0, 0, 0, 0);
         cyc(0, 0, 0, 0, 0, 0, 0, 1, 'h41);
      end
      check("t6_hsat", 32'(hit_count), 32'd15);
      cyc(0, 1, 'h42, 4, 30, 5, 0, 0, 0);
      cyc(0, 1, 'h43, 2, 40, 6, 1, 0, 0);
      cyc(1, 1, 'h44, 1, 0, 0, 1, 1, 'h42);
      check("t6_rst_nact", 32'(n_active), 32'd0);
      check("t6_rst_hcnt", 32'(hit_count), 32'd0);
      peek(0, "t6_rst_slot0", 0, 0, 0, 0);

      // Random traffic, including spawns at or beyond the floor
      for (int n = 0; n < 600; n++) begin
         r   = ($urandom_range(0, 199) == 0) ? 1 : 0;
         sp  = int'($urandom_range(0, 1));
         ch  = 'h41 + int'($urandom_range(0, 3));
         spd = int'($urandom_range(0, 7));
         x   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(440, 511)) : int'($urandom_range(0, 300));
         y   = int'($urandom_range(0, 639));
         ft  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         kv  = ($urandom_range(0, 2) == 0) ? 1 : 0;
         ka  = 'h41 + int'($urandom_range(0, 4));
         cyc(r, sp, ch, spd, x, y, ft, kv, ka);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
